// File: rtl/regfile_ctx_engine_if.sv
// Register-file and context-stream bundle between regfile_ctx_engine (master)
// and the register file / context path (slave).
interface regfile_ctx_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;

  logic              save_valid;
  logic              save_ready;
  logic [DATA_W-1:0] save_data;

  logic              restore_valid;
  logic              restore_ready;
  logic [DATA_W-1:0] restore_data;

  modport master (
    output rf_read_addr,
    input  rf_read_data,
    output rf_write_addr,
    output rf_write_data,
    output rf_write_enable,
    output save_valid,
    input  save_ready,
    output save_data,
    input  restore_valid,
    output restore_ready,
    input  restore_data
  );

  modport slave (
    input  rf_read_addr,
    output rf_read_data,
    input  rf_write_addr,
    input  rf_write_data,
    input  rf_write_enable,
    input  save_valid,
    output save_ready,
    input  save_data,
    output restore_valid,
    input  restore_ready,
    output restore_data
  );
endinterface

// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine: streams the register file out and back in.
// Optional trailing XOR checksum word enabled by defining CTX_CHECKSUM_EN.
module regfile_ctx_engine #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_save,
  input  logic                 start_restore,
  output logic                 busy,
  output logic                 done,
  output logic                 chk_err,
  regfile_ctx_engine_if.master ctx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE       = 3'd1,
    ST_SAVE_CK    = 3'd2,
    ST_RESTORE    = 3'd3,
    ST_RESTORE_CK = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              start_c;
  logic              save_hs_c;
  logic              restore_hs_c;
  logic              word_hs_c;
  logic              is_last_c;

  // Handshakes derived from the state register and peer inputs only.
  assign start_c      = (state == ST_IDLE) && (start_save || start_restore);
  assign save_hs_c    = ((state == ST_SAVE) || (state == ST_SAVE_CK)) && ctx.save_ready;
  assign restore_hs_c = ((state == ST_RESTORE) || (state == ST_RESTORE_CK)) && ctx.restore_valid;
  assign word_hs_c    = ((state == ST_SAVE) && ctx.save_ready) ||
                        ((state == ST_RESTORE) && ctx.restore_valid);
  assign is_last_c    = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_save)         state_nxt = ST_SAVE;
        else if (start_restore) state_nxt = ST_RESTORE;
      end
      ST_SAVE: begin
`ifdef CTX_CHECKSUM_EN
        if (save_hs_c && is_last_c) state_nxt = ST_SAVE_CK;
`else
        if (save_hs_c && is_last_c) state_nxt = ST_DONE;
`endif
      end
      ST_SAVE_CK: begin
        if (save_hs_c) state_nxt = ST_DONE;
      end
      ST_RESTORE: begin
`ifdef CTX_CHECKSUM_EN
        if (restore_hs_c && is_last_c) state_nxt = ST_RESTORE_CK;
`else
        if (restore_hs_c && is_last_c) state_nxt = ST_DONE;
`endif
      end
      ST_RESTORE_CK: begin
        if (restore_hs_c) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CTX_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  // Output decode; write strobe is only ever asserted in a data handshake cycle.
  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    ctx.save_valid      = 1'b0;
    ctx.restore_ready   = 1'b0;
    ctx.rf_write_enable = 1'b0;
    ctx.rf_read_addr    = idx;
    ctx.rf_write_addr   = idx;
    ctx.rf_write_data   = ctx.restore_data;
    ctx.save_data       = ctx.rf_read_data;
    unique case (state)
      ST_IDLE: ;
      ST_SAVE: begin
        busy           = 1'b1;
        ctx.save_valid = 1'b1;
      end
      ST_SAVE_CK: begin
        busy           = 1'b1;
        ctx.save_valid = 1'b1;
`ifdef CTX_CHECKSUM_EN
        ctx.save_data  = acc;
`endif
      end
      ST_RESTORE: begin
        busy                = 1'b1;
        ctx.restore_ready   = 1'b1;
        ctx.rf_write_enable = ctx.restore_valid;
      end
      ST_RESTORE_CK: begin
        busy              = 1'b1;
        ctx.restore_ready = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Index saturates at the terminal register so it never wraps inside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (start_c) begin
      idx <= '0;
    end else if (word_hs_c && !is_last_c) begin
      idx <= idx + ADDR_W'(1);
    end
  end

`ifdef CTX_CHECKSUM_EN
  logic [DATA_W-1:0] word_c;
  assign word_c = (state == ST_SAVE) ? ctx.rf_read_data : ctx.restore_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      chk_err <= 1'b0;
    end else if (start_c) begin
      acc     <= '0;
      chk_err <= 1'b0;
    end else begin
      if (word_hs_c) acc <= acc ^ word_c;
      if ((state == ST_RESTORE_CK) && restore_hs_c) chk_err <= (ctx.restore_data != acc);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine with a behavioural 8x16 register file.
// Honours CTX_CHECKSUM_EN for frame length and checksum scenarios.
module tb_regfile_ctx_engine;

`ifdef CTX_CHECKSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk;
  logic reset;
  logic start_save;
  logic start_restore;
  logic busy;
  logic done;
  logic chk_err;

  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] exp_w [9];

  int n_cmp;
  int n_err;

  regfile_ctx_engine_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

  regfile_ctx_engine #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_save    (start_save),
    .start_restore (start_restore),
    .busy          (busy),
    .done          (done),
    .chk_err       (chk_err),
    .ctx           (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.rf_read_data = rf[ifc.rf_read_addr];

  always @(posedge clk) begin
    if (ifc.rf_write_enable) rf[ifc.rf_write_addr] <= ifc.rf_write_data;
    else if (pl_en)          rf[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < 8; i++) begin
      pl_en = 1'b1; pl_addr = 3'(i); pl_data = base + 16'(i) * step;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  function automatic logic [15:0] xor8();
    logic [15:0] x = '0;
    for (int i = 0; i < 8; i++) x ^= exp_w[i];
    return x;
  endfunction

  task automatic do_start(input logic s, input logic r);
    start_save = s; start_restore = r;
    @(posedge clk); #1;
    start_save = 1'b0; start_restore = 1'b0;
  endtask

  task automatic check_done();
    #1;
    check("done_pulse", done, 1'b1);
    check("busy_in_done", busy, 1'b1);
    check("valid_in_done", ifc.save_valid, 1'b0);
    @(posedge clk); #1;
    check("done_cleared", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
  endtask

  // Accept FL save words; while stalled the offered word must be the pending one.
  task automatic save_frame(input bit bp);
    int cnt = 0;
    int cyc = 0;
    while (cnt < FL && cyc < 200) begin
      ifc.save_ready = bp ? (cyc % 2 == 1) : 1'b1;
      #1;
      check("save_valid", ifc.save_valid, 1'b1);
      check("save_data", ifc.save_data, exp_w[cnt]);
      check("restore_ready_in_save", ifc.restore_ready, 1'b0);
      check("busy_in_save", busy, 1'b1);
      if (ifc.save_ready) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check("save_word_count", cnt, FL);
    ifc.save_ready = 1'b0;
    check_done();
  endtask

  // Feed exp_w words until 'stop' handshakes; optional valid gaps.
  task automatic restore_frame(input int stop, input bit gap);
    int n = 0;
    int cyc = 0;
    while (n < stop && cyc < 200) begin
      ifc.restore_valid = gap ? (cyc % 3 != 2) : 1'b1;
      ifc.restore_data  = ifc.restore_valid ? exp_w[n] : 16'hDEAD;
      #1;
      check("restore_ready", ifc.restore_ready, 1'b1);
      check("save_valid_in_restore", ifc.save_valid, 1'b0);
      check("rf_we", ifc.rf_write_enable, ifc.restore_valid && (n < 8));
      if (ifc.restore_valid && n < 8) check("rf_waddr", ifc.rf_write_addr, n);
      if (ifc.restore_valid) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("restore_word_count", n, stop);
    ifc.restore_valid = 1'b0;
    if (stop == FL) check_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start_save = 1'b0; start_restore = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    ifc.save_ready = 1'b0; ifc.restore_valid = 1'b0; ifc.restore_data = 16'h0000;

    // Reset state, with register file preloaded so save_data is defined.
    preload(16'h1000, 16'h0001);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_chk_err", chk_err, 1'b0);
    check("rst_save_valid", ifc.save_valid, 1'b0);
    check("rst_restore_ready", ifc.restore_ready, 1'b0);
    check("rst_rf_we", ifc.rf_write_enable, 1'b0);
    check("rst_rf_raddr", ifc.rf_read_addr, 3'd0);
    check("rst_rf_waddr", ifc.rf_write_addr, 3'd0);
    check("rst_save_data", ifc.save_data, 16'h1000);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Save without back-pressure.
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h1000 + 16'(i);
    exp_w[8] = 16'h0000;
    do_start(1'b1, 1'b0);
    save_frame(1'b0);

    // Save with back-pressure.
    preload(16'h2000, 16'h0111);
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h2000 + 16'(i) * 16'h0111;
    exp_w[8] = xor8();
    do_start(1'b1, 1'b0);
    save_frame(1'b1);

    // Restore with valid gaps.
    for (int i = 0; i < 8; i++) exp_w[i] = 16'hA5A0 + 16'(i);
    exp_w[8] = 16'h0000;
    do_start(1'b0, 1'b1);
    restore_frame(FL, 1'b1);
    check("r3_after_restore", rf[3], 16'hA5A3);
    check("r7_after_restore", rf[7], 16'hA5A7);
    check("chk_err_good_restore", chk_err, 1'b0);

`ifdef CTX_CHECKSUM_EN
    // Checksum: matching trailer, then mismatching trailer held until next start.
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h0001;
    exp_w[8] = 16'h0000;
    do_start(1'b0, 1'b1);
    restore_frame(FL, 1'b0);
    check("chk_err_match", chk_err, 1'b0);
    exp_w[8] = 16'h0001;
    do_start(1'b0, 1'b1);
    restore_frame(FL, 1'b0);
    check("chk_err_mismatch", chk_err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("chk_err_sticky", chk_err, 1'b1);
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h0001;
    exp_w[8] = 16'h0000;
    do_start(1'b1, 1'b0);
    check("chk_err_cleared_on_start", chk_err, 1'b0);
    save_frame(1'b0);
`endif

    // Simultaneous starts: save wins, no restore.
    preload(16'h3000, 16'h0003);
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h3000 + 16'(i) * 16'h0003;
    exp_w[8] = xor8();
    do_start(1'b1, 1'b1);
    save_frame(1'b0);
    #1;
    check("no_restore_after_dual", ifc.restore_ready, 1'b0);

    // Reset after the 4th restore word.
    preload(16'h5550, 16'h0001);
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h7770 + 16'(i);
    do_start(1'b0, 1'b1);
    restore_frame(4, 1'b0);
    ifc.restore_valid = 1'b1;
    ifc.restore_data  = 16'hBEEF;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_we", ifc.rf_write_enable, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ifc.restore_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("postrst_done", done, 1'b0);
      check("postrst_busy", busy, 1'b0);
    end
    for (int i = 0; i < 4; i++) check("rst_kept_written", rf[i], 16'h7770 + 16'(i));
    for (int i = 4; i < 8; i++) check("rst_untouched", rf[i], 16'h5550 + 16'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_ctx_engine.md
# regfile_ctx_engine

Context save/restore engine that is the master side of the 8×16 register file. On command, it sequentially reads every register and streams the words out over a valid/ready interface. It can also accept a word stream and write it back into the registers. It sits between the register file ports and the debug/interrupt context path, so the file's contents can be spilled to memory and reloaded without core involvement.

## Interface
- NUM_REGS, 8, number of registers transferred per context
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; NUM_REGS ≤ 2**ADDR_W

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- start_save  in  1  single-cycle request to save context
- start_restore  in  1  single-cycle request to restore context
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse on transfer completion
- chk_err  out  1  restore checksum mismatch, sticky until next start
- rf_read_addr  out  ADDR_W  register file read address
- rf_read_data  in  DATA_W  register file read data (combinational from rf_read_addr)
- rf_write_addr  out  ADDR_W  register file write address
- rf_write_data  out  DATA_W  register file write data
- rf_write_enable  out  1  register file write strobe
- save_valid / save_ready / save_data  out/in/out  1/1/DATA_W  outbound context stream
- restore_valid / restore_ready / restore_data  in/out/in  1/1/DATA_W  inbound context stream

## Operation
- FSM states: IDLE, SAVE, SAVE_CK, RESTORE, RESTORE_CK, DONE.
- Index counter idx (ADDR_W bits) and XOR accumulator acc (DATA_W bits).
- **IDLE:**
  - start_save → SAVE; start_restore → RESTORE.
  - Both asserted in the same cycle: save wins, and the restore request is dropped.
  - On entry to either transfer: idx=0, acc=0, chk_err=0.
  - Starts received outside IDLE are ignored.
- **SAVE:**
  - rf_read_addr=idx, save_valid=1, save_data=rf_read_data.
  - On a save handshake (valid&&ready): acc^=save_data and idx++.
  - Handshake with idx==NUM_REGS-1 → SAVE_CK if CTX_CHECKSUM_EN, else DONE.
- **SAVE_CK:** save_valid=1, save_data=acc. On handshake → DONE.
- **RESTORE:**
  - restore_ready=1.
  - On a restore handshake: rf_write_enable=1, rf_write_addr=idx, rf_write_data=restore_data. These are combinational and valid in the handshake cycle only.
  - Also on handshake: acc^=restore_data and idx++.
  - Last index → RESTORE_CK if CTX_CHECKSUM_EN, else DONE.
- **RESTORE_CK:**
  - restore_ready=1, no register write.
  - On handshake: chk_err=(restore_data!=acc), then → DONE.
- **DONE:** done=1 for one cycle, then → IDLE.
- Outputs outside the states above:
  - save_valid, restore_ready and rf_write_enable are 0.
  - rf_read_addr=idx.
  - rf_write_addr=idx and rf_write_data=restore_data; these are don't-care while the strobe is low.
- Stalls: save_valid is held while save_ready=0, and save_data stays stable because idx is frozen.

## Timing
- **Reset values:**
  - state=IDLE, idx=0, acc=0.
  - busy=0, done=0, chk_err=0.
  - save_valid=0, restore_ready=0, rf_write_enable=0.
  - rf_read_addr=0, rf_write_addr=0.
  - save_data=rf_read_data of register 0; rf_write_data=restore_data.
- **Latency:**
  - First save word is valid in the cycle after start_save is sampled.
  - With no back-pressure: save takes NUM_REGS(+1) transfer cycles plus 1 DONE cycle.
  - busy is high from the cycle after start through the DONE cycle inclusive.
- Register file writes take effect at the posedge that ends the handshake cycle.
- Reset asserted mid-transfer:
  - Immediate return to IDLE, with no further writes and no done pulse.
  - Registers already written keep their new values.
- The idx counter never wraps within a transfer; the terminal index is NUM_REGS-1.

## Configuration
- CTX_CHECKSUM_EN defined:
  - Save appends a trailing XOR word; restore consumes and checks it, driving chk_err.
  - Frames are NUM_REGS+1 words.
- CTX_CHECKSUM_EN undefined:
  - SAVE_CK and RESTORE_CK are unreachable, and frames are exactly NUM_REGS words.
  - chk_err is tied 0 and acc may be removed.

## Test plan
- Save with no back-pressure:
  - Preload r0..r7 = 0x1000+i, pulse start_save, hold save_ready=1.
  - Required: words 0x1000..0x1007 on 8 consecutive cycles, done 1 cycle after last word.
  - With macro: 9th word 0x0000.
- Save with back-pressure:
  - Toggle save_ready every other cycle.
  - Required: no word dropped or repeated, and save_data stable while stalled.
- Restore:
  - Stream 0xA5A0+i for i=0..7, with restore_valid gaps.
  - Required: rf_write_enable only on handshakes, r3 reads 0xA5A3 afterwards.
- Checksum (macro on):
  - Restore 8 words of 0x0001 with trailer 0x0000 → chk_err=0.
  - Trailer 0x0001 → chk_err=1, held until the next start.
- Simultaneous start_save and start_restore → save frame only, restore_ready stays 0.
- Reset asserted after the 4th restore word:
  - Required: r0..r3 updated, r4..r7 unchanged.
  - Required: busy=0 and done never pulses.
